// File: rtl/pipe_out_block_ctrl_if.sv
// Host block-pipe / output-FIFO signal bundle for pipe_out_block_ctrl.
// master: the block controller; slave: the FIFO and host side.
interface pipe_out_block_ctrl_if #(
    parameter int unsigned COUNT_W = 10
);
    logic [31:0]        fifo_dout;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_rd_count;
    logic               fifo_rd_en;
    logic               pipe_rd_strobe;
    logic               pipe_ready;
    logic [31:0]        pipe_data;
    logic [15:0]        blocks_done;
    logic               proto_err;
    logic               underrun;

    modport master (
        input  fifo_dout, fifo_empty, fifo_rd_count, pipe_rd_strobe,
        output fifo_rd_en, pipe_ready, pipe_data, blocks_done, proto_err, underrun
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_rd_count, pipe_rd_strobe,
        input  fifo_rd_en, pipe_ready, pipe_data, blocks_done, proto_err, underrun
    );
endinterface

// File: rtl/pipe_out_block_ctrl.sv
// Streams whole BLOCK_WORDS-sized blocks from the output FIFO to the host block pipe.
// Optional PIPE_OUT_PAD_EN: slots strobed while the FIFO is empty read back as zero.
module pipe_out_block_ctrl #(
    parameter int unsigned BLOCK_WORDS = 128,
    parameter int unsigned COUNT_W     = 10
) (
    input  logic                         okClk,
    input  logic                         reset_n,
    pipe_out_block_ctrl_if.master        bus
);
    localparam int unsigned WC_W = $clog2(BLOCK_WORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;

    logic [1:0]         state, state_next;
    logic [WC_W-1:0]    word_cnt, word_cnt_next;
    logic [15:0]        blocks_done, blocks_done_next;
    logic               proto_err, proto_err_next;
    logic               underrun, underrun_next;
    logic [COUNT_W-1:0] rd_count;
    logic               in_block;
    logic               count_ok;
    logic               last_word;

    assign rd_count  = bus.fifo_rd_count;
    assign in_block  = (state == ARMED) || (state == XFER);
    assign count_ok  = 32'(rd_count) >= BLOCK_WORDS;
    assign last_word = word_cnt == WC_W'(BLOCK_WORDS - 1);

    // Slots strobed on an empty FIFO still advance word_cnt but never read.
    assign bus.fifo_rd_en = bus.pipe_rd_strobe && in_block && !bus.fifo_empty;

    always_comb begin
        state_next       = state;
        word_cnt_next    = word_cnt;
        blocks_done_next = blocks_done;
        proto_err_next   = proto_err || (bus.pipe_rd_strobe && (state == IDLE));
        underrun_next    = underrun || (bus.pipe_rd_strobe && in_block && bus.fifo_empty);
        case (state)
            IDLE: begin
                if (count_ok) begin
                    state_next = ARMED;
                end
            end
            ARMED, XFER: begin
                if (bus.pipe_rd_strobe) begin
                    if (last_word) begin
                        state_next       = IDLE;
                        word_cnt_next    = '0;
                        blocks_done_next = blocks_done + 16'd1;
                    end else begin
                        state_next    = XFER;
                        word_cnt_next = word_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            word_cnt    <= '0;
            blocks_done <= '0;
            proto_err   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_next;
            word_cnt    <= word_cnt_next;
            blocks_done <= blocks_done_next;
            proto_err   <= proto_err_next;
            underrun    <= underrun_next;
        end
    end

    // pipe_ready is a pure decode of the state register, so it is glitch-free.
    assign bus.pipe_ready  = (state == ARMED);
    assign bus.blocks_done = blocks_done;
    assign bus.proto_err   = proto_err;
    assign bus.underrun    = underrun;

`ifdef PIPE_OUT_PAD_EN
    logic rd_done;

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            rd_done <= 1'b0;
        end else begin
            rd_done <= bus.fifo_rd_en;
        end
    end

    assign bus.pipe_data = rd_done ? bus.fifo_dout : 32'h0000_0000;
`else
    assign bus.pipe_data = bus.fifo_dout;
`endif

endmodule

// File: doc/pipe_out_block_ctrl.md
PIPE_OUT_BLOCK_CTRL -- requirements
Module: pipe_out_block_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 128, meaning 32-bit words per host block (power of 2, 4..512).
REQ-002 SHALL have parameter COUNT_W, default 10, meaning width of the FIFO read-count input.
REQ-003 SHALL have port okClk  input  1  single clock for all logic; one clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port fifo_dout  input  32  read data from the 64-to-32 output FIFO, valid one cycle after fifo_rd_en.
REQ-006 SHALL have port fifo_empty  input  1  output FIFO empty flag.
REQ-007 SHALL have port fifo_rd_count  input  COUNT_W  output FIFO read-side word count.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have port pipe_rd_strobe  input  1  host block-pipe read strobe, one word per asserted cycle.
REQ-010 SHALL have port pipe_ready  output  1  a full block is available to the host.
REQ-011 SHALL have port pipe_data  output  32  word presented to the host.
REQ-012 SHALL have port blocks_done  output  16  completed-block counter.
REQ-013 SHALL have port proto_err  output  1  sticky: strobe received outside a block.
REQ-014 SHALL have port underrun  output  1  sticky: strobe received in a block while FIFO empty.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, XFER, plus a word counter word_cnt of log2(BLOCK_WORDS) bits.
REQ-016 IDLE SHALL move to ARMED on the clock edge where fifo_rd_count >= BLOCK_WORDS; pipe_ready SHALL be registered, high exactly in ARMED.
REQ-017 ARMED SHALL move to XFER on the first pipe_rd_strobe; that strobe counts as word 0 and pipe_ready SHALL drop the following cycle.
REQ-018 fifo_rd_en SHALL be combinational: pipe_rd_strobe AND state in {ARMED, XFER} AND NOT fifo_empty.
REQ-019 Read latency SHALL be one cycle: data for a strobe at cycle t appears on pipe_data at cycle t+1.
REQ-020 word_cnt SHALL increment on every strobe in ARMED/XFER, whether or not the FIFO was read.
REQ-021 Strobe with word_cnt = BLOCK_WORDS-1 SHALL return the FSM to IDLE, clear word_cnt, and increment blocks_done (mod 2^16).
REQ-022 From IDLE after a block, re-arm SHALL need a fresh count check; no back-to-back arm in the same cycle as block end.
REQ-023 Strobe in IDLE SHALL not read the FIFO and SHALL set proto_err.
REQ-024 Strobe in ARMED/XFER with fifo_empty high SHALL not read the FIFO and SHALL set underrun.
REQ-025 fifo_rd_count falling while ARMED SHALL NOT disarm; only this block reads the FIFO.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, word_cnt 0, fifo_rd_en 0, pipe_ready 0, pipe_data 0, blocks_done 0, proto_err 0, underrun 0.
REQ-027 Reset mid-block SHALL abandon the partial block without counting it; the next block starts at word 0.

Configuration
REQ-028 Macro PIPE_OUT_PAD_EN defined: a slot strobed while fifo_empty SHALL present 32'h00000000 on pipe_data at t+1, via a registered read-occurred flag.
REQ-029 PIPE_OUT_PAD_EN undefined: pipe_data SHALL equal fifo_dout directly, with no pad logic; underrun detection SHALL remain.

Verification
REQ-030 Arming: fill 127 words -> pipe_ready 0; 128th word -> pipe_ready 1 one cycle after count reaches 128.
REQ-031 Full block: 128 consecutive strobes on a FIFO holding 0x000fffff.. -> 128 fifo_rd_en pulses, pipe_data matches FIFO order at t+1, blocks_done 0->1, state IDLE.
REQ-032 Gapped strobes: 128 strobes with 1-cycle gaps -> identical data sequence, blocks_done 1, no errors.
REQ-033 Underrun: 100 words loaded, force arm, 128 strobes -> underrun 1 at strobe 101; slots 101-128 read 0x00000000 with PIPE_OUT_PAD_EN, else no extra fifo_rd_en; blocks_done 1.
REQ-034 Protocol error: strobe in IDLE -> proto_err 1, fifo_rd_en 0, FIFO count unchanged.
REQ-035 Reset at word 60 -> all outputs 0 immediately, then 256 words loaded -> two full blocks, blocks_done 2.
